// File: rtl/sdram_row_buffer.sv
// Row-buffer controller: activates one core row into a 64x32 latch and serves wrapped column bursts.
// Optional build macro SDRAM_ROWBUF_WRMASK_EN adds a per-byte write mask (WrMask).
module sdram_row_buffer #(
    parameter int ROW_AW = 4,
    parameter int BURST  = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [2:0]        Cmd,
    input  logic [ROW_AW-1:0] RowAddr,
    input  logic [5:0]        ColAddr,
    input  logic [31:0]       WrData,
`ifdef SDRAM_ROWBUF_WRMASK_EN
    input  logic [3:0]        WrMask,
`endif
    output logic [31:0]       RdData,
    output logic              RdValid,
    output logic              Busy,
    output logic              CmdErr,
    output logic [ROW_AW-1:0] CoreRowSel,
    output logic              CoreRowEnable,
    output logic              CoreRE,
    output logic              CoreWE,
    input  logic [2047:0]     CoreRowIn,
    output logic [2047:0]     CoreRowOut
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [5:0] MASK = 6'(BURST - 1);
    localparam logic [CW-1:0] LAST = CW'(BURST - 1);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        ACT,
        ACT_CAP,
        ACTIVE,
        RD_BURST,
        WR_BURST,
        PRE_WB
    } state_t;

    state_t              state;
    logic                dirty;
    logic [ROW_AW-1:0]   open_row;
    logic [5:0]          col_base;
    logic [CW-1:0]       cnt;
    logic [2047:0]       rowbuf;
    logic [5:0]          col;
    logic [3:0]          byte_en;
    logic                wr_beat;
    logic                cmd_any;

    // Wrap stays inside the BURST-aligned block of columns.
    function automatic logic [5:0] beat_col(input logic [5:0] base,
                                            input logic [CW-1:0] i);
        return (base & ~MASK) | ((base + 6'(i)) & MASK);
    endfunction

`ifdef SDRAM_ROWBUF_WRMASK_EN
    assign byte_en = WrMask;
`else
    assign byte_en = 4'hF;
`endif

    assign col = (state == ACTIVE) ? ColAddr : beat_col(col_base, cnt);
    assign wr_beat = ((state == ACTIVE) && (Cmd == CMD_WR)) ||
                     (state == WR_BURST);
    assign cmd_any = (Cmd != CMD_NOP);
    assign CoreRowOut = rowbuf;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            dirty         <= 1'b0;
            open_row      <= '0;
            col_base      <= '0;
            cnt           <= '0;
            RdData        <= '0;
            RdValid       <= 1'b0;
            Busy          <= 1'b0;
            CmdErr        <= 1'b0;
            CoreRowSel    <= '0;
            CoreRowEnable <= 1'b0;
            CoreRE        <= 1'b0;
            CoreWE        <= 1'b0;
        end else begin
            CmdErr  <= 1'b0;
            RdValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Cmd == CMD_ACT) begin
                        open_row      <= RowAddr;
                        state         <= ACT;
                        Busy          <= 1'b1;
                        CoreRowEnable <= 1'b1;
                        CoreRE        <= 1'b1;
                        CoreRowSel    <= RowAddr;
                    end else begin
                        CmdErr <= cmd_any;
                    end
                end
                ACT: begin
                    state  <= ACT_CAP;
                    CmdErr <= cmd_any;
                end
                ACT_CAP: begin
                    rowbuf        <= CoreRowIn;
                    dirty         <= 1'b0;
                    state         <= ACTIVE;
                    Busy          <= 1'b0;
                    CoreRowEnable <= 1'b0;
                    CoreRE        <= 1'b0;
                    CoreRowSel    <= '0;
                    CmdErr        <= cmd_any;
                end
                ACTIVE: begin
                    case (Cmd)
                        CMD_NOP: ;
                        CMD_RD: begin
                            RdData   <= rowbuf[{col, 5'd0} +: 32];
                            RdValid  <= 1'b1;
                            col_base <= ColAddr;
                            cnt      <= CW'(1);
                            if (BURST > 1) begin
                                state <= RD_BURST;
                                Busy  <= 1'b1;
                            end
                        end
                        CMD_WR: begin
                            dirty    <= 1'b1;
                            col_base <= ColAddr;
                            cnt      <= CW'(1);
                            if (BURST > 1) begin
                                state <= WR_BURST;
                                Busy  <= 1'b1;
                            end
                        end
                        CMD_PRE: begin
                            if (dirty) begin
                                state         <= PRE_WB;
                                Busy          <= 1'b1;
                                CoreRowEnable <= 1'b1;
                                CoreWE        <= 1'b1;
                                CoreRowSel    <= open_row;
                            end else begin
                                state <= IDLE;
                            end
                        end
                        default: CmdErr <= 1'b1;
                    endcase
                end
                RD_BURST: begin
                    RdData  <= rowbuf[{col, 5'd0} +: 32];
                    RdValid <= 1'b1;
                    cnt     <= cnt + 1'b1;
                    CmdErr  <= cmd_any;
                    if (cnt == LAST) begin
                        state <= ACTIVE;
                        Busy  <= 1'b0;
                    end
                end
                WR_BURST: begin
                    dirty  <= 1'b1;
                    cnt    <= cnt + 1'b1;
                    CmdErr <= cmd_any;
                    if (cnt == LAST) begin
                        state <= ACTIVE;
                        Busy  <= 1'b0;
                    end
                end
                PRE_WB: begin
                    dirty         <= 1'b0;
                    state         <= IDLE;
                    Busy          <= 1'b0;
                    CoreRowEnable <= 1'b0;
                    CoreWE        <= 1'b0;
                    CoreRowSel    <= '0;
                    CmdErr        <= cmd_any;
                end
                default: state <= IDLE;
            endcase
            if (wr_beat) begin
                for (int k = 0; k < 4; k++) begin
                    if (byte_en[k])
                        rowbuf[{col, 2'(k), 3'd0} +: 8] <= WrData[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_row_buffer.sv
// Self-checking bench for sdram_row_buffer: directed steps plus random row traffic vs. a word-array model.
// Honours SDRAM_ROWBUF_WRMASK_EN when defined.
module tb_sdram_row_buffer;

    localparam int ROW_AW = 4;
    localparam int B = 4;
    localparam logic [2:0] NOP = 3'd0;
    localparam logic [2:0] ACT = 3'd1;
    localparam logic [2:0] RD  = 3'd2;
    localparam logic [2:0] WR  = 3'd3;
    localparam logic [2:0] PRE = 3'd4;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic [2:0]        Cmd = NOP;
    logic [ROW_AW-1:0] RowAddr = '0;
    logic [5:0]        ColAddr = '0;
    logic [31:0]       WrData = '0;
    logic [3:0]        WrMask = 4'hF;
    logic [31:0]       RdData;
    logic              RdValid;
    logic              Busy;
    logic              CmdErr;
    logic [ROW_AW-1:0] CoreRowSel;
    logic              CoreRowEnable;
    logic              CoreRE;
    logic              CoreWE;
    logic [2047:0]     CoreRowIn;
    logic [2047:0]     CoreRowOut;

    logic [2047:0] core_mem [16];
    logic [31:0]   buf_m [64];
    logic          dirty_m;
    int            row_m;

    int n_assert = 0;
    int n_fail = 0;

    int            we_pulses = 0;
    logic [2047:0] wb_data;
    int            wb_row;

    sdram_row_buffer #(.ROW_AW(ROW_AW), .BURST(B)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Cmd(Cmd),
        .RowAddr(RowAddr),
        .ColAddr(ColAddr),
        .WrData(WrData),
`ifdef SDRAM_ROWBUF_WRMASK_EN
        .WrMask(WrMask),
`endif
        .RdData(RdData),
        .RdValid(RdValid),
        .Busy(Busy),
        .CmdErr(CmdErr),
        .CoreRowSel(CoreRowSel),
        .CoreRowEnable(CoreRowEnable),
        .CoreRE(CoreRE),
        .CoreWE(CoreWE),
        .CoreRowIn(CoreRowIn),
        .CoreRowOut(CoreRowOut)
    );

    always #5 Clk = ~Clk;

    assign CoreRowIn = core_mem[CoreRowSel];

    always @(posedge Clk) begin
        if (!Reset && CoreWE) begin
            we_pulses <= we_pulses + 1;
            wb_data   <= CoreRowOut;
            wb_row    <= int'(CoreRowSel);
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bcol(input int base, input int i);
        return base - (base % B) + ((base % B) + i) % B;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++)
            if (m[k]) r[8*k +: 8] = new_w[8*k +: 8];
        return r;
    endfunction

    function automatic logic [3:0] eff_mask(input logic [3:0] m);
`ifdef SDRAM_ROWBUF_WRMASK_EN
        return m;
`else
        return m | 4'hF;
`endif
    endfunction

    function automatic int first_diff(input logic [2047:0] v);
        for (int w = 0; w < 64; w++)
            if (v[w*32 +: 32] !== buf_m[w]) return w;
        return -1;
    endfunction

    function automatic logic [2047:0] flat_buf();
        logic [2047:0] f;
        for (int w = 0; w < 64; w++) f[w*32 +: 32] = buf_m[w];
        return f;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rddata"}, RdData, 0);
        check({tag, "_rdvalid"}, RdValid, 0);
        check({tag, "_busy"}, Busy, 0);
        check({tag, "_cmderr"}, CmdErr, 0);
        check({tag, "_rowsel"}, CoreRowSel, 0);
        check({tag, "_rowen"}, CoreRowEnable, 0);
        check({tag, "_re"}, CoreRE, 0);
        check({tag, "_we"}, CoreWE, 0);
    endtask

    task automatic activate(input int row);
        Cmd = ACT;
        RowAddr = ROW_AW'(row);
        step();
        Cmd = NOP;
        RowAddr = ROW_AW'($urandom);
        for (int k = 0; k < 2; k++) begin
            check("act_busy", Busy, 1);
            check("act_re", CoreRE, 1);
            check("act_en", CoreRowEnable, 1);
            check("act_sel", CoreRowSel, row);
            check("act_we", CoreWE, 0);
            check("act_err", CmdErr, 0);
            step();
        end
        check("act_done_busy", Busy, 0);
        check("act_done_re", CoreRE, 0);
        for (int w = 0; w < 64; w++) buf_m[w] = core_mem[row][w*32 +: 32];
        dirty_m = 1'b0;
        row_m = row;
    endtask

    task automatic read_burst(input int col, input logic [2:0] inj);
        Cmd = RD;
        ColAddr = 6'(col);
        step();
        Cmd = NOP;
        for (int i = 0; i < B; i++) begin
            if (i > 0) step();
            check("rd_valid", RdValid, 1);
            check("rd_data", RdData, buf_m[bcol(col, i)]);
            check("rd_busy", Busy, (i < B - 1) ? 1 : 0);
            check("rd_err", CmdErr, (inj != NOP && i == 1) ? 1 : 0);
            if (i == 0) begin
                Cmd = inj;
                WrData = $urandom;
                ColAddr = 6'($urandom);
            end else begin
                Cmd = NOP;
            end
        end
    endtask

    task automatic write_burst(input int col, input logic [31:0] d [B],
                               input logic [3:0] m [B]);
        int c;
        for (int i = 0; i < B; i++) begin
            Cmd = (i == 0) ? WR : NOP;
            ColAddr = (i == 0) ? 6'(col) : 6'($urandom);
            WrData = d[i];
            WrMask = m[i];
            if (i > 0) begin
                check("wr_busy", Busy, 1);
                check("wr_err", CmdErr, 0);
            end
            c = bcol(col, i);
            buf_m[c] = merge(buf_m[c], d[i], eff_mask(m[i]));
            dirty_m = 1'b1;
            step();
        end
        Cmd = NOP;
        check("wr_done_busy", Busy, 0);
        check("wr_done_err", CmdErr, 0);
    endtask

    task automatic precharge();
        int wp0;
        wp0 = we_pulses;
        Cmd = PRE;
        step();
        Cmd = NOP;
        if (dirty_m) begin
            check("pre_busy", Busy, 1);
            check("pre_we", CoreWE, 1);
            check("pre_en", CoreRowEnable, 1);
            check("pre_sel", CoreRowSel, row_m);
            check("pre_rowout_bad_word", first_diff(CoreRowOut), -1);
            step();
            check("pre_done_busy", Busy, 0);
            check("pre_done_we", CoreWE, 0);
            check("pre_done_en", CoreRowEnable, 0);
            check("pre_wb_row", wb_row, row_m);
            check("pre_wb_bad_word", first_diff(wb_data), -1);
            core_mem[row_m] = flat_buf();
        end else begin
            check("pre_clean_busy", Busy, 0);
            check("pre_clean_we", CoreWE, 0);
        end
        check("pre_we_pulses", we_pulses - wp0, dirty_m ? 1 : 0);
        dirty_m = 1'b0;
    endtask

    initial begin
        logic [31:0] d [B];
        logic [3:0]  m [B];
        int          wp0;
        int          row;
        int          col;

        for (int r = 0; r < 16; r++)
            for (int w = 0; w < 64; w++)
                core_mem[r][w*32 +: 32] = $urandom;
        core_mem[3][10*32 +: 32] = 32'h11223344;
        core_mem[5][20*32 +: 32] = 32'h11223344;
        dirty_m = 1'b0;
        row_m = 0;

        Reset = 1'b1;
        repeat (3) step();
        check_reset_outputs("reset");
        Reset = 1'b0;
        step();

        activate(3);
        read_burst(10, NOP);
        Cmd = NOP;
        step();
        check("rd_idle_valid", RdValid, 0);

        Cmd = ACT;
        RowAddr = 4'd5;
        step();
        Cmd = NOP;
        check("act_in_active_err", CmdErr, 1);
        check("act_in_active_busy", Busy, 0);
        check("act_in_active_re", CoreRE, 0);
        step();
        check("act_in_active_err_clr", CmdErr, 0);

        read_burst(9, WR);
        read_burst(10, NOP);
        read_burst(33, NOP);
        step();
        check("b2b_end_valid", RdValid, 0);
        precharge();

        Cmd = RD;
        step();
        Cmd = NOP;
        check("rd_in_idle_err", CmdErr, 1);
        check("rd_in_idle_valid", RdValid, 0);
        check("rd_in_idle_busy", Busy, 0);
        Cmd = 3'd7;
        step();
        Cmd = NOP;
        check("illegal_err_a", CmdErr, 1);
        step();
        check("illegal_err_clr", CmdErr, 0);

        activate(3);
        d[0] = 32'hA0000001; d[1] = 32'hB0000002;
        d[2] = 32'hC0000003; d[3] = 32'hD0000004;
        for (int i = 0; i < B; i++) m[i] = 4'hF;
        write_burst(62, d, m);
        precharge();
        check("wb_col62", wb_data[62*32 +: 32], 32'hA0000001);
        check("wb_col63", wb_data[63*32 +: 32], 32'hB0000002);
        check("wb_col60", wb_data[60*32 +: 32], 32'hC0000003);
        check("wb_col61", wb_data[61*32 +: 32], 32'hD0000004);

        activate(5);
        d[0] = 32'hAABBCCDD;
        m[0] = 4'b0011;
        for (int i = 1; i < B; i++) begin
            d[i] = $urandom;
            m[i] = 4'($urandom);
        end
        write_burst(20, d, m);
        read_burst(20, NOP);
        precharge();

        for (int it = 0; it < 8; it++) begin
            row = $urandom_range(0, 15);
            activate(row);
            for (int op = 0; op < 4; op++) begin
                col = $urandom_range(0, 63);
                if ($urandom_range(0, 1) == 1) begin
                    read_burst(col, NOP);
                end else begin
                    for (int i = 0; i < B; i++) begin
                        d[i] = $urandom;
                        m[i] = 4'($urandom);
                    end
                    write_burst(col, d, m);
                end
            end
            Cmd = NOP;
            step();
            precharge();
        end

        activate(7);
        for (int i = 0; i < B; i++) begin
            d[i] = $urandom;
            m[i] = 4'hF;
        end
        write_burst(12, d, m);
        Cmd = PRE;
        step();
        Cmd = NOP;
        check("rst_prewb_busy", Busy, 1);
        check("rst_prewb_we", CoreWE, 1);
        Reset = 1'b1;
        wp0 = we_pulses;
        step();
        check_reset_outputs("rst_prewb");
        check("rst_prewb_no_wb", we_pulses - wp0, 0);
        Reset = 1'b0;
        dirty_m = 1'b0;
        step();
        activate(7);
        read_burst(12, NOP);
        Cmd = NOP;
        step();
        precharge();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_row_buffer.md
# sdram_row_buffer

Row-buffer (sense-amp latch) controller between the SDRAM command decoder and the MemCoreRow array. It activates one row into a local 64 x 32-bit buffer and serves fixed-length column bursts from that buffer. On precharge it writes the buffer back to the core only if the buffer was modified.

## Interface
Parameters:
- ROW_AW, 4, row address width (2^ROW_AW rows)
- BURST, 4, burst length in words; power of two, 1..64

Ports:
- Clk  in  1  clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- Cmd  in  3  0=NOP, 1=ACTIVATE, 2=READ, 3=WRITE, 4=PRECHARGE, others illegal
- RowAddr  in  ROW_AW  row for ACTIVATE
- ColAddr  in  6  start column for READ/WRITE
- WrData  in  32  write beat data
- RdData  out  32  read beat data, registered
- RdValid  out  1  RdData valid
- Busy  out  1  commands ignored while high
- CmdErr  out  1  one-cycle pulse: illegal, out-of-state or busy-time command
- CoreRowSel  out  ROW_AW  row select to core
- CoreRowEnable, CoreRE, CoreWE  out  1 each  core controls
- CoreRowIn  in  2048  core row data, word i = bits [32i+31:32i]
- CoreRowOut  out  2048  buffer contents to core

## Operation
- States: IDLE, ACT, ACT_CAP, ACTIVE, RD_BURST, WR_BURST, PRE_WB.
- IDLE + ACTIVATE: latch RowAddr into open-row register, go to ACT. Other non-NOP commands raise CmdErr.
- ACT: drive CoreRowEnable=1, CoreRE=1, CoreRowSel=open row, then go to ACT_CAP.
- ACT_CAP: keep the same drive and capture CoreRowIn into the buffer at the cycle-end edge. Clear dirty. Go to ACTIVE.
- ACTIVE + READ: go to RD_BURST. Beat i reads column {ColAddr[5:b], (ColAddr[b-1:0]+i) mod BURST}, where b=log2(BURST). Wrap stays inside the aligned burst and never crosses into the next block.
- ACTIVE + WRITE: beat 0 = WrData on the command cycle, beats 1..BURST-1 on the following cycles, same column sequence. Each beat sets dirty. BURST=1 completes in the command cycle and stays in ACTIVE.
- ACTIVE + PRECHARGE: if dirty, go to PRE_WB; if clean, go to IDLE.
- ACTIVE + ACTIVATE: CmdErr. Precharge is required first.
- PRE_WB: drive CoreRowEnable=1, CoreWE=1, CoreRowSel=open row, CoreRowOut=buffer for one cycle. Clear dirty. Go to IDLE.
- CoreRowOut always reflects the buffer. Core controls are 0 outside ACT, ACT_CAP and PRE_WB.
- Burst counter is log2(BURST) bits. The last beat is when counter = BURST-1.
- Any non-NOP command while Busy=1 is dropped and pulses CmdErr. It does not alter the burst in progress.

## Timing
- Reset values: RdData=0, RdValid=0, Busy=0, CmdErr=0, CoreRowSel=0, CoreRowEnable=0, CoreRE=0, CoreWE=0. State=IDLE, dirty=0. Buffer contents are don't-care.
- Reset asserted mid-burst or in PRE_WB aborts immediately: no writeback, all outputs take reset values on the next edge.
- ACTIVATE at cycle t: Busy=1 at t+1 and t+2, ACTIVE at t+3 (tRCD = 3 cycles including the command cycle).
- READ at t: RdValid=1 and beats at t+1..t+BURST. Busy=1 at t+1..t+BURST-1. A READ at t+BURST is accepted, so back-to-back bursts have no gap.
- WRITE at t: data sampled at t..t+BURST-1. Busy=1 at t+1..t+BURST-1. A READ at t+BURST returns the new data.
- PRECHARGE at t: if dirty, PRE_WB at t+1 with Busy=1 and IDLE at t+2; if clean, IDLE at t+1 with Busy=0.
- CmdErr is asserted the cycle after the offending command, for one cycle.

## Configuration
- SDRAM_ROWBUF_WRMASK_EN defined: adds input WrMask[3:0]. On each write beat, byte k of the word is updated only if WrMask[k]=1. A beat with WrMask=0 still sets dirty.
- Not defined: no WrMask port, and all four bytes are written on every beat.

## Test plan
- Reset, ACTIVATE row 3 with CoreRowIn word10=32'h11223344 -> core RE pulse in cycles t+1..t+2 with CoreRowSel=3. A BURST=4 READ at col 10 then returns 32'h11223344 first at t+1, followed by cols 11, 8, 9.
- ACTIVATE, WRITE col 62 with data A,B,C,D, PRECHARGE -> cols 62, 63, 60, 61 = A, B, C, D on CoreRowOut. A single CoreWE pulse occurs, then IDLE.
- ACTIVATE, READ only, PRECHARGE -> no CoreWE pulse, IDLE one cycle after PRECHARGE.
- READ in IDLE, ACTIVATE in ACTIVE, and WRITE issued mid-read-burst -> each produces one CmdErr pulse with state and data unchanged.
- Back-to-back READs at t and t+4 (BURST=4) -> 8 consecutive RdValid cycles.
- Reset asserted during PRE_WB -> next cycle all outputs 0, state IDLE. With SDRAM_ROWBUF_WRMASK_EN, WrMask=4'b0011 writing 32'hAABBCCDD over 32'h11223344 -> 32'h1122CCDD.
